// File: rtl/byte_striping_n_if.sv
// rtl/byte_striping_n_if.sv - stream and lane bundle for the round-robin byte-striping distributor
//
// Parameters: LANES (power of two, 2..8), WIDTH (8..64, multiple of 8).
// Signals:
//   valid_in    data_in carries a valid word this cycle
//   data_in     input word, WIDTH bits
//   valid_out   per-lane valid, bit k belongs to lane k
//   lane_out    lane k occupies bits [k*WIDTH +: WIDTH]
//   lane_ptr    lane the next valid word will be written to
//   group_done  one-cycle pulse after the word for lane LANES-1 is written
// Modports: master drives the input word, slave is the distributor.

interface byte_striping_n_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 32,
    parameter int PTR_W = (LANES > 2) ? $clog2(LANES) : 1
);
    logic                   valid_in;
    logic [WIDTH-1:0]       data_in;
    logic [LANES-1:0]       valid_out;
    logic [LANES*WIDTH-1:0] lane_out;
    logic [PTR_W-1:0]       lane_ptr;
    logic                   group_done;

    modport master (
        output valid_in,
        output data_in,
        input  valid_out,
        input  lane_out,
        input  lane_ptr,
        input  group_done
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output valid_out,
        output lane_out,
        output lane_ptr,
        output group_done
    );
endinterface

// File: rtl/byte_striping_n.sv
// rtl/byte_striping_n.sv - round-robin word distributor onto LANES output lanes with cascaded idle drain
//
// Optional feature macro: STRIPE_REALIGN_EN (lane_ptr returns to 0 when input goes idle).
//
// Parameters: LANES (power of two, 2..8), WIDTH (8..64, multiple of 8),
//             IDLE_WORD (value a cleared lane register takes).
// Ports:
//   clk_2f_c   input   striping clock, all state updates on its rising edge
//   reset      input   synchronous, active-low
//   bus        slave   byte_striping_n_if: valid_in/data_in in,
//                      valid_out/lane_out/lane_ptr/group_done out

module byte_striping_n #(
    parameter int              LANES     = 2,
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic             clk_2f_c,
    input  logic             reset,
    byte_striping_n_if.slave bus
);
    localparam int PTR_W = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    logic [LANES-1:0][WIDTH-1:0] lane_q, lane_d;
    logic [LANES-1:0]            valid_q, valid_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic                        done_q, done_d;

    always_ff @(posedge clk_2f_c) begin
        if (!reset) begin
            lane_q  <= {LANES{IDLE_WORD}};
            valid_q <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        lane_d  = lane_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;

        if (bus.valid_in) begin
            // A write always wins; the drain simply pauses for this cycle.
            lane_d[ptr_q]  = bus.data_in;
            valid_d[ptr_q] = 1'b1;
            // LANES is a power of two, so the natural wrap of ptr_q is the modulo.
            ptr_d          = ptr_q + 1'b1;
            done_d         = (ptr_q == LAST_LANE);
        end else begin
            lane_d[0]  = IDLE_WORD;
            valid_d[0] = 1'b0;
            // Each lane clears only once its lower neighbour was already empty
            // before this edge, so a full group empties one lane per idle cycle.
            for (int k = 1; k < LANES; k++) begin
                if (!valid_q[k-1]) begin
                    lane_d[k]  = IDLE_WORD;
                    valid_d[k] = 1'b0;
                end
            end
`ifdef STRIPE_REALIGN_EN
            // Clearing on every idle cycle is the same as clearing on the first
            // one: after that the pointer is already 0 until the next word.
            ptr_d = '0;
`else
            ptr_d = ptr_q;
`endif
        end
    end

    assign bus.lane_out   = lane_q;
    assign bus.valid_out  = valid_q;
    assign bus.lane_ptr   = ptr_q;
    assign bus.group_done = done_q;

endmodule

// File: tb/tb_byte_striping_n.sv
// tb/tb_byte_striping_n.sv - directed-vector bench for byte_striping_n (2x32 and 4x16 instances)

module tb_byte_striping_n;
    localparam logic [15:0] IDLE_B = 16'hDEAD;

    logic clk_2f_c;
    logic reset;
    int   checks;
    int   failures;

    byte_striping_n_if #(.LANES(2), .WIDTH(32)) a_if ();
    byte_striping_n_if #(.LANES(4), .WIDTH(16)) b_if ();

    byte_striping_n #(.LANES(2), .WIDTH(32), .IDLE_WORD(32'h0)) u_a (
        .clk_2f_c (clk_2f_c),
        .reset    (reset),
        .bus      (a_if.slave)
    );

    byte_striping_n #(.LANES(4), .WIDTH(16), .IDLE_WORD(IDLE_B)) u_b (
        .clk_2f_c (clk_2f_c),
        .reset    (reset),
        .bus      (b_if.slave)
    );

    initial clk_2f_c = 1'b0;
    always #5 clk_2f_c = ~clk_2f_c;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2f_c);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d);
        a_if.valid_in = v;
        a_if.data_in  = d;
        tick();
    endtask

    task automatic drive_b(input logic v, input logic [15:0] d);
        b_if.valid_in = v;
        b_if.data_in  = d;
        tick();
    endtask

    task automatic check_b(input string tag, input logic [3:0] vo, input logic [63:0] lanes,
                           input logic [1:0] ptr, input logic done);
        check_eq({tag, ".valid"}, 64'(b_if.valid_out), 64'(vo));
        check_eq({tag, ".lanes"}, 64'(b_if.lane_out), lanes);
        check_eq({tag, ".ptr"}, 64'(b_if.lane_ptr), 64'(ptr));
        check_eq({tag, ".done"}, 64'(b_if.group_done), 64'(done));
    endtask

    task automatic check_a(input string tag, input logic [1:0] vo, input logic [63:0] lanes,
                           input logic ptr, input logic done);
        check_eq({tag, ".valid"}, 64'(a_if.valid_out), 64'(vo));
        check_eq({tag, ".lanes"}, 64'(a_if.lane_out), lanes);
        check_eq({tag, ".ptr"}, 64'(a_if.lane_ptr), 64'(ptr));
        check_eq({tag, ".done"}, 64'(a_if.group_done), 64'(done));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        a_if.valid_in = 1'b0;
        a_if.data_in  = '0;
        b_if.valid_in = 1'b0;
        b_if.data_in  = '0;
        tick();
        tick();
        check_a("rst_a", 2'b00, 64'h0, 1'b0, 1'b0);
        check_b("rst_b", 4'b0000, {4{IDLE_B}}, 2'd0, 1'b0);
        reset = 1'b1;

        // Two lanes, 32 bits: four back-to-back words.
        drive_a(1'b1, 32'hFFFF_0001);
        check_a("a_w1", 2'b01, {32'h0, 32'hFFFF_0001}, 1'b1, 1'b0);
        drive_a(1'b1, 32'hFFFF_0002);
        check_a("a_w2", 2'b11, {32'hFFFF_0002, 32'hFFFF_0001}, 1'b0, 1'b1);
        drive_a(1'b1, 32'hFFFF_0003);
        check_a("a_w3", 2'b11, {32'hFFFF_0002, 32'hFFFF_0003}, 1'b1, 1'b0);
        drive_a(1'b1, 32'hFFFF_0004);
        check_a("a_w4", 2'b11, {32'hFFFF_0004, 32'hFFFF_0003}, 1'b0, 1'b1);
        drive_a(1'b0, 32'h0);
        check_a("a_idle1", 2'b10, {32'hFFFF_0004, 32'h0}, 1'b0, 1'b0);
        drive_a(1'b0, 32'h0);
        check_a("a_idle2", 2'b00, 64'h0, 1'b0, 1'b0);

        // Four lanes, 16 bits: full group then four-cycle cascaded drain.
        drive_b(1'b1, 16'h00A0);
        check_b("b_w0", 4'b0001, {IDLE_B, IDLE_B, IDLE_B, 16'h00A0}, 2'd1, 1'b0);
        drive_b(1'b1, 16'h00A1);
        drive_b(1'b1, 16'h00A2);
        check_b("b_w2", 4'b0111, {IDLE_B, 16'h00A2, 16'h00A1, 16'h00A0}, 2'd3, 1'b0);
        drive_b(1'b1, 16'h00A3);
        check_b("b_w3", 4'b1111, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 2'd0, 1'b1);
        drive_b(1'b0, 16'h0);
        check_b("b_d1", 4'b1110, {16'h00A3, 16'h00A2, 16'h00A1, IDLE_B}, 2'd0, 1'b0);
        drive_b(1'b0, 16'h0);
        check_b("b_d2", 4'b1100, {16'h00A3, 16'h00A2, IDLE_B, IDLE_B}, 2'd0, 1'b0);
        drive_b(1'b0, 16'h0);
        check_b("b_d3", 4'b1000, {16'h00A3, IDLE_B, IDLE_B, IDLE_B}, 2'd0, 1'b0);
        drive_b(1'b0, 16'h0);
        check_b("b_d4", 4'b0000, {4{IDLE_B}}, 2'd0, 1'b0);

        // Three words, two idle cycles, one word.
        drive_b(1'b1, 16'h00B0);
        drive_b(1'b1, 16'h00B1);
        drive_b(1'b1, 16'h00B2);
        check_b("b_p3", 4'b0111, {IDLE_B, 16'h00B2, 16'h00B1, 16'h00B0}, 2'd3, 1'b0);
        drive_b(1'b0, 16'h0);
        drive_b(1'b0, 16'h0);
`ifdef STRIPE_REALIGN_EN
        check_b("b_gap", 4'b0100, {IDLE_B, 16'h00B2, IDLE_B, IDLE_B}, 2'd0, 1'b0);
        drive_b(1'b1, 16'h00B3);
        check_b("b_resume", 4'b0101, {IDLE_B, 16'h00B2, IDLE_B, 16'h00B3}, 2'd1, 1'b0);
`else
        check_b("b_gap", 4'b0100, {IDLE_B, 16'h00B2, IDLE_B, IDLE_B}, 2'd3, 1'b0);
        drive_b(1'b1, 16'h00B3);
        check_b("b_resume", 4'b1100, {16'h00B3, 16'h00B2, IDLE_B, IDLE_B}, 2'd0, 1'b1);
`endif
        for (int i = 0; i < 4; i++) drive_b(1'b0, 16'h0);
        check_b("b_clear", 4'b0000, {4{IDLE_B}}, 2'd0, 1'b0);

        // Reset mid-group takes priority over a simultaneous valid word.
        drive_b(1'b1, 16'h00C0);
        check_b("b_pre_rst", 4'b0001, {IDLE_B, IDLE_B, IDLE_B, 16'h00C0}, 2'd1, 1'b0);
        reset = 1'b0;
        drive_b(1'b1, 16'h00C1);
        check_b("b_mid_rst", 4'b0000, {4{IDLE_B}}, 2'd0, 1'b0);
        reset = 1'b1;
        drive_b(1'b1, 16'h00C2);
        check_b("b_post_rst", 4'b0001, {IDLE_B, IDLE_B, IDLE_B, 16'h00C2}, 2'd1, 1'b0);

        // Resume mid-drain: fill, one idle cycle, then a word on lane 0.
        drive_b(1'b1, 16'h00D1);
        drive_b(1'b1, 16'h00D2);
        drive_b(1'b1, 16'h00D3);
        check_b("b_full", 4'b1111, {16'h00D3, 16'h00D2, 16'h00D1, 16'h00C2}, 2'd0, 1'b1);
        drive_b(1'b0, 16'h0);
        check_b("b_part", 4'b1110, {16'h00D3, 16'h00D2, 16'h00D1, IDLE_B}, 2'd0, 1'b0);
        drive_b(1'b1, 16'h0055);
        check_b("b_refill", 4'b1111, {16'h00D3, 16'h00D2, 16'h00D1, 16'h0055}, 2'd1, 1'b0);
        b_if.valid_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_striping_n.md
# byte_striping_n

Parametrised round-robin byte-striping distributor for the physical-layer transmit path, running in the 2f clock domain. Each valid input word goes to exactly one of LANES output lanes in strict rotation, so the lanes can be serialised at the 1f rate downstream. Lane registers drain one lane per cycle when input goes idle. A lane pointer and a group-complete pulse are exported so the un-striping block and the checker can track alignment.

## Interface
- LANES, 2: number of output lanes; power of two, 2..8.
- WIDTH, 32: word width in bits; 8..64, multiple of 8.
- IDLE_WORD, 0: value loaded into a lane register when that lane is cleared; WIDTH bits.

- clk_2f_c  input  1  striping clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low.
- valid_in  input  1  data_in carries a valid word this cycle.
- data_in  input  WIDTH  input word.
- valid_out  output  LANES  per-lane valid; bit k belongs to lane k.
- lane_out  output  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- lane_ptr  output  max(1,log2 LANES)  lane that the next valid word will be written to.
- group_done  output  1  one-cycle pulse after the word for lane LANES-1 is written.

## Operation
- Reset: sampled on clk_2f_c while reset=0. It forces valid_out=0, every lane_out slice=IDLE_WORD, lane_ptr=0 and group_done=0. Reset has priority over all other activity, including mid-group.
- Stripe (valid_in=1):
  - lane[lane_ptr] <= data_in; valid_out[lane_ptr] <= 1.
  - lane_ptr <= (lane_ptr+1) mod LANES, wrapping from LANES-1 to 0.
  - All other lanes hold their data and valid.
- Idle (valid_in=0), cascaded drain:
  - Lane 0: valid_out[0] <= 0 and lane 0 <= IDLE_WORD.
  - Lane k≥1: cleared in the same way only if valid_out[k-1] is already 0 before this edge; otherwise it holds.
  - Result: with all lanes valid, lane k clears on the (k+1)th consecutive idle cycle.
  - lane_ptr holds, unless STRIPE_REALIGN_EN is defined (see Configuration).
- Resuming after a partial drain: the write to lane[lane_ptr] takes priority. The drain does not advance on valid_in=1 cycles.
- group_done <= 1 exactly when a valid word is written with lane_ptr=LANES-1; otherwise 0.
- State: lane_ptr counter, LANES×WIDTH data registers, LANES valid flops, group_done flop. There is no other FSM state.

## Timing
- Latency: a word sampled at edge n appears on its lane after edge n and stays there until overwritten or drained.
- Throughput: one word per clk_2f_c cycle; each lane updates at most once per LANES valid cycles.
- Lane k is stable for at least LANES cycles under continuous valid_in, which gives the downstream 1f capture window when LANES=2.
- No backpressure; valid_in is never stalled.
- Drain of a full group takes LANES idle cycles.
- group_done is coincident with valid_out[LANES-1] first rising within a group.

## Configuration
- STRIPE_REALIGN_EN defined:
  - On the first idle cycle following any valid cycle, lane_ptr <= 0.
  - Every burst therefore starts on lane 0. A burst whose length is not a multiple of LANES leaves the tail lanes holding stale-but-draining data.
- STRIPE_REALIGN_EN undefined:
  - lane_ptr holds across idle gaps.
  - Striping continues on the lane after the last one written, so no lane slot is skipped across bursts.

## Test plan
- LANES=2, WIDTH=32: after reset, send 0xFFFF_0001, 0xFFFF_0002, 0xFFFF_0003, 0xFFFF_0004 back-to-back.
  - Expect lane0=…01 then …03, lane1=…02 then …04.
  - Expect valid_out=01,11,11,11.
  - Expect group_done high after the 2nd and 4th words.
- LANES=4, WIDTH=16: send 0xA0..0xA3 back-to-back, then 4 idle cycles.
  - Expect valid_out=1111 after the 4th word.
  - During the idle cycles expect 1110,1100,1000,0000, each cleared lane = IDLE_WORD.
- LANES=4: send 3 words, 2 idle cycles, then 1 word.
  - Without the macro: the 4th word lands on lane 3 and group_done pulses.
  - With STRIPE_REALIGN_EN: it lands on lane 0 with lane_ptr=1 and no group_done.
- Reset mid-group: assert reset=0 for one cycle after 1 of 4 words.
  - Expect all outputs zero/IDLE_WORD and lane_ptr=0 next cycle.
  - The next word goes to lane 0.
- Resume mid-drain, LANES=4, all valid: 1 idle cycle (valid_out=1110), then word 0x55 with lane_ptr=0.
  - Expect lane0=0x55 and valid_out=1111.
  - Lanes 1..3 unchanged.
